// File: rtl/display_pkg.sv
// Shared constants and types for the display memory-port arbiter.
package display_pkg;

  localparam int BURST_WORDS = 4;
  localparam int ADDR_W      = 22;
  localparam int DATA_W      = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    DATA = 2'd2
  } arb_state_t;

  localparam logic [1:0] REQ_CTRL  = 2'd0;
  localparam logic [1:0] REQ_FILE0 = 2'd1;
  localparam logic [1:0] REQ_FILE1 = 2'd2;

endpackage

// File: rtl/rr_priority_picker.sv
// Combinational winner search: optional fixed priority for requester 0,
// otherwise round-robin upward from the last non-priority winner.
module rr_priority_picker #(
  parameter int NUM_REQ = 3
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [1:0]         rr_last_i,
  input  logic               prio0_en_i,
  output logic [1:0]         winner_o,
  output logic               found_o
);

  // Priority override first, then a wrap-around scan starting after rr_last.
  always_comb begin
    int idx;
    idx      = 0;
    winner_o = '0;
    found_o  = 1'b0;
    if (prio0_en_i && req_i[0]) begin
      found_o = 1'b1;
    end else begin
      for (int k = 1; k <= NUM_REQ; k++) begin
        idx = (int'(rr_last_i) + k) % NUM_REQ;
        if (!found_o && req_i[idx] && !(prio0_en_i && idx == 0)) begin
          winner_o = 2'(idx);
          found_o  = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/display_bus_arbiter.sv
// Shares the burst-read memory port between the control reader and the two
// display file fetchers, one 4-beat burst per grant.
//
//  state | meaning
//  IDLE  | no owner; arbitrate among active requests
//  ADDR  | owner's address presented (mem_as=1), waiting for mem_ack
//  DATA  | address accepted, collecting the remaining data beats
module display_bus_arbiter #(
  parameter int NUM_REQ     = 3,
  parameter int BURST_WORDS = display_pkg::BURST_WORDS,
  parameter int PRIO0       = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NUM_REQ-1:0]    req_as,
  input  logic [NUM_REQ*22-1:0] req_address,
  output logic [NUM_REQ-1:0]    req_ack,
  output logic [NUM_REQ-1:0]    req_burstdata_valid,
  output logic [15:0]           req_din,
  output logic                  mem_as,
  output logic [21:0]           mem_address,
  input  logic                  mem_ack,
  input  logic                  mem_burstdata_valid,
  input  logic [15:0]           mem_din,
  output logic                  grant_valid,
  output logic [1:0]            grant_idx
);
  import display_pkg::*;

  localparam int               CNT_W      = $clog2(BURST_WORDS) + 1;
  localparam logic [CNT_W-1:0] BEATS_FULL = CNT_W'(BURST_WORDS);
  localparam logic [CNT_W-1:0] BEATS_LAST = CNT_W'(BURST_WORDS - 1);

  arb_state_t         state_q, state_d;
  logic [1:0]         grant_idx_q, grant_idx_d;
  logic [1:0]         rr_last_q, rr_last_d;
  logic [CNT_W-1:0]   beat_cnt_q, beat_cnt_d;

  logic [NUM_REQ-1:0] grant_oh;
  logic               owner_req;
  logic               busy;
  logic               ack_now;
  logic               beat;
  logic               last_beat;
  logic [1:0]         pick_idx;
  logic               pick_found;

  rr_priority_picker #(.NUM_REQ(NUM_REQ)) u_picker (
    .req_i      (req_as),
    .rr_last_i  (rr_last_q),
    .prio0_en_i (PRIO0 != 0),
    .winner_o   (pick_idx),
    .found_o    (pick_found)
  );

  // Decode the owner into a one-hot select and mux its address to memory.
  always_comb begin
    grant_oh    = '0;
    mem_address = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant_idx_q == 2'(i)) begin
        grant_oh[i] = 1'b1;
        mem_address = req_address[i*22 +: 22];
      end
    end
  end

  assign owner_req = |(req_as & grant_oh);
  assign busy      = (state_q != IDLE);
  assign ack_now   = (state_q == ADDR) && mem_ack;
  assign beat      = busy && mem_burstdata_valid;
  // Final beat is either already counted (beats ran ahead of the ack) or arriving now.
  assign last_beat = (beat_cnt_q == BEATS_FULL) || (beat && beat_cnt_q == BEATS_LAST);

  assign mem_as              = (state_q == ADDR);
  assign req_ack             = ack_now ? grant_oh : '0;
  assign req_burstdata_valid = beat ? grant_oh : '0;
  assign req_din             = mem_din;
  assign grant_valid         = busy;
  assign grant_idx           = grant_idx_q;

  // Next-state: arbitration, address handshake, beat counting and completion.
  always_comb begin
    state_d     = state_q;
    grant_idx_d = grant_idx_q;
    rr_last_d   = rr_last_q;
    beat_cnt_d  = beat_cnt_q;
    if (beat && beat_cnt_q != BEATS_FULL) begin
      beat_cnt_d = beat_cnt_q + CNT_W'(1);
    end
    case (state_q)
      IDLE: begin
        beat_cnt_d = '0;
        if (pick_found) begin
          grant_idx_d = pick_idx;
          if (!(PRIO0 != 0 && pick_idx == REQ_CTRL)) begin
            rr_last_d = pick_idx;
          end
          state_d = ADDR;
        end
      end
      ADDR: begin
        if (mem_ack) begin
          if (last_beat) begin
            state_d    = IDLE;
            beat_cnt_d = '0;
          end else begin
            state_d = DATA;
          end
        end else if (!owner_req) begin
          state_d    = IDLE;
          beat_cnt_d = '0;
        end
      end
      DATA: begin
        if (last_beat) begin
          state_d    = IDLE;
          beat_cnt_d = '0;
        end
      end
      default: begin
        state_d    = IDLE;
        beat_cnt_d = '0;
      end
    endcase
  end

  // State registers with synchronous reset; an in-flight burst is simply dropped.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      grant_idx_q <= '0;
      rr_last_q   <= 2'(NUM_REQ - 1);
      beat_cnt_q  <= '0;
    end else begin
      state_q     <= state_d;
      grant_idx_q <= grant_idx_d;
      rr_last_q   <= rr_last_d;
      beat_cnt_q  <= beat_cnt_d;
    end
  end

endmodule

// File: tb/tb_display_bus_arbiter.sv
// Bench for display_bus_arbiter: directed bursts plus random traffic, every
// cycle compared against a transaction-level reference model.
module tb_display_bus_arbiter;
  import display_pkg::*;

  localparam int N  = 3;
  localparam int BW = BURST_WORDS;

  logic            clk = 1'b0;
  logic            reset;
  logic [N-1:0]    req_as;
  logic [N*22-1:0] req_address;
  logic [N-1:0]    req_ack;
  logic [N-1:0]    req_burstdata_valid;
  logic [15:0]     req_din;
  logic            mem_as;
  logic [21:0]     mem_address;
  logic            mem_ack;
  logic            mem_burstdata_valid;
  logic [15:0]     mem_din;
  logic            grant_valid;
  logic [1:0]      grant_idx;

  always #5 clk = ~clk;

  display_bus_arbiter #(.NUM_REQ(N), .BURST_WORDS(BW), .PRIO0(1)) dut (
    .clk                 (clk),
    .reset               (reset),
    .req_as              (req_as),
    .req_address         (req_address),
    .req_ack             (req_ack),
    .req_burstdata_valid (req_burstdata_valid),
    .req_din             (req_din),
    .mem_as              (mem_as),
    .mem_address         (mem_address),
    .mem_ack             (mem_ack),
    .mem_burstdata_valid (mem_burstdata_valid),
    .mem_din             (mem_din),
    .grant_valid         (grant_valid),
    .grant_idx           (grant_idx)
  );

  int n_total = 0;
  int n_bad   = 0;

  // Reference model: owner of the port, beats received, ack received, rr pointer.
  bit   m_busy;
  bit   m_acked;
  int   m_owner;
  int   m_beats;
  int   m_last;
  logic [21:0] addr_tab[N];

  // Sampled observations for the directed checks.
  logic        s_gv;
  logic [1:0]  s_gidx;
  logic        s_mem_as;
  logic [21:0] s_addr;
  logic        s_val_any;
  int          s_ack_cnt;
  int          s_val_cnt[N];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_busy  = 1'b0;
    m_acked = 1'b0;
    m_owner = 0;
    m_beats = 0;
    m_last  = N - 1;
  endtask

  task automatic clr_counts();
    s_ack_cnt = 0;
    for (int i = 0; i < N; i++) s_val_cnt[i] = 0;
  endtask

  // One clock: drive inputs, compare all outputs against the model, advance the model.
  task automatic step(input logic rst, input logic [N-1:0] rq, input logic ack, input logic bt);
    logic [N-1:0] e_ack;
    logic [N-1:0] e_val;
    int w;
    int idx;
    @(posedge clk);
    #1;
    reset               = rst;
    req_as              = rq;
    mem_ack             = ack;
    mem_burstdata_valid = bt;
    mem_din             = 16'($urandom);
    #3;
    e_ack = (m_busy && !m_acked && ack) ? N'(1 << m_owner) : '0;
    e_val = (m_busy && bt) ? N'(1 << m_owner) : '0;
    chk("mem_as",    {31'd0, mem_as},      {31'd0, m_busy && !m_acked});
    chk("grant_vld", {31'd0, grant_valid}, {31'd0, m_busy});
    chk("grant_idx", {30'd0, grant_idx},   32'(m_owner));
    chk("req_ack",   32'(req_ack),         32'(e_ack));
    chk("beat_vld",  32'(req_burstdata_valid), 32'(e_val));
    chk("req_din",   {16'd0, req_din},     {16'd0, mem_din});
    if (m_busy) chk("mem_addr", {10'd0, mem_address}, {10'd0, addr_tab[m_owner]});
    s_gv      = grant_valid;
    s_gidx    = grant_idx;
    s_mem_as  = mem_as;
    s_addr    = mem_address;
    s_val_any = |req_burstdata_valid;
    s_ack_cnt += $countones(req_ack);
    for (int i = 0; i < N; i++) s_val_cnt[i] += int'(req_burstdata_valid[i]);
    if (rst) begin
      model_reset();
    end else if (!m_busy) begin
      w = -1;
      if (rq[0]) begin
        w = 0;
      end else begin
        for (int k = 1; k <= N; k++) begin
          idx = (m_last + k) % N;
          if (w < 0 && idx != 0 && rq[idx]) w = idx;
        end
      end
      if (w >= 0) begin
        m_busy  = 1'b1;
        m_acked = 1'b0;
        m_beats = 0;
        m_owner = w;
        if (w != 0) m_last = w;
      end
    end else if (!m_acked && !ack && !rq[m_owner]) begin
      m_busy  = 1'b0;
      m_beats = 0;
    end else begin
      m_acked = m_acked || ack;
      if (bt && m_beats < BW) m_beats++;
      if (m_acked && m_beats == BW) begin
        m_busy  = 1'b0;
        m_acked = 1'b0;
        m_beats = 0;
      end
    end
  endtask

  // Full burst from an IDLE cycle: arbitrate, ack (optionally with beat 1), beats.
  task automatic do_burst(input logic [N-1:0] rq, input logic [1:0] exp_owner, input bit ack_with_beat);
    step(1'b0, rq, 1'b0, 1'b0);
    chk("idle_gap", {31'd0, s_gv}, 32'd0);
    step(1'b0, rq, 1'b1, ack_with_beat);
    chk("burst_owner", {30'd0, s_gidx}, {30'd0, exp_owner});
    for (int b = 0; b < (ack_with_beat ? BW - 1 : BW); b++) step(1'b0, rq, 1'b0, 1'b1);
  endtask

  initial begin
    logic [N-1:0] rq;
    bit ack;
    reset = 1'b1;
    req_as = '0;
    mem_ack = 1'b0;
    mem_burstdata_valid = 1'b0;
    mem_din = '0;
    for (int i = 0; i < N; i++) begin
      addr_tab[i] = 22'($urandom);
      req_address[i*22 +: 22] = addr_tab[i];
    end
    model_reset();
    clr_counts();

    // Reset values.
    step(1'b1, '0, 1'b0, 1'b0);
    step(1'b0, '0, 1'b0, 1'b0);
    chk("rst_gv", {31'd0, s_gv}, 32'd0);
    chk("rst_gidx", {30'd0, s_gidx}, 32'd0);
    chk("rst_mem_as", {31'd0, s_mem_as}, 32'd0);

    // Single requester 1, ack three cycles into ADDR, four beats.
    clr_counts();
    step(1'b0, 3'b010, 1'b0, 1'b0);
    step(1'b0, 3'b010, 1'b0, 1'b0);
    chk("t1_mem_as", {31'd0, s_mem_as}, 32'd1);
    chk("t1_addr", {10'd0, s_addr}, {10'd0, addr_tab[REQ_FILE0]});
    step(1'b0, 3'b010, 1'b0, 1'b0);
    step(1'b0, 3'b010, 1'b1, 1'b0);
    for (int b = 0; b < BW; b++) step(1'b0, 3'b010, 1'b0, 1'b1);
    step(1'b0, 3'b000, 1'b0, 1'b0);
    chk("t1_idle", {31'd0, s_gv}, 32'd0);
    chk("t1_acks", 32'(s_ack_cnt), 32'd1);
    chk("t1_beats1", 32'(s_val_cnt[1]), 32'(BW));
    chk("t1_beats_other", 32'(s_val_cnt[0] + s_val_cnt[2]), 32'd0);

    // Round robin between the two display files.
    step(1'b1, '0, 1'b0, 1'b0);
    do_burst(3'b110, REQ_FILE0, 1'b0);
    do_burst(3'b110, REQ_FILE1, 1'b0);
    do_burst(3'b110, REQ_FILE0, 1'b0);
    do_burst(3'b110, REQ_FILE1, 1'b0);

    // Control reader priority, then round robin resumes once it withdraws.
    do_burst(3'b111, REQ_CTRL, 1'b0);
    do_burst(3'b111, REQ_CTRL, 1'b0);
    do_burst(3'b110, REQ_FILE0, 1'b0);
    do_burst(3'b110, REQ_FILE1, 1'b0);

    // Ack coincides with beat 1, back-to-back beats.
    clr_counts();
    do_burst(3'b010, REQ_FILE0, 1'b1);
    step(1'b0, 3'b000, 1'b0, 1'b0);
    chk("t4_idle", {31'd0, s_gv}, 32'd0);
    chk("t4_acks", 32'(s_ack_cnt), 32'd1);
    chk("t4_beats", 32'(s_val_cnt[1]), 32'(BW));

    // Requester 2 withdraws in ADDR before ack.
    clr_counts();
    step(1'b1, '0, 1'b0, 1'b0);
    step(1'b0, 3'b100, 1'b0, 1'b0);
    step(1'b0, 3'b100, 1'b0, 1'b0);
    chk("t5_mem_as", {31'd0, s_mem_as}, 32'd1);
    chk("t5_gidx", {30'd0, s_gidx}, {30'd0, REQ_FILE1});
    step(1'b0, 3'b000, 1'b0, 1'b0);
    step(1'b0, 3'b000, 1'b0, 1'b0);
    chk("t5_abort_as", {31'd0, s_mem_as}, 32'd0);
    chk("t5_abort_gv", {31'd0, s_gv}, 32'd0);
    chk("t5_no_ack", 32'(s_ack_cnt), 32'd0);

    // Reset after beat 2 drops the burst.
    step(1'b0, 3'b010, 1'b0, 1'b0);
    step(1'b0, 3'b010, 1'b1, 1'b0);
    step(1'b0, 3'b010, 1'b0, 1'b1);
    step(1'b0, 3'b010, 1'b0, 1'b1);
    step(1'b1, 3'b000, 1'b0, 1'b0);
    step(1'b0, 3'b000, 1'b0, 1'b1);
    chk("t6_gv", {31'd0, s_gv}, 32'd0);
    chk("t6_mem_as", {31'd0, s_mem_as}, 32'd0);
    chk("t6_gidx", {30'd0, s_gidx}, 32'd0);
    chk("t6_no_route", {31'd0, s_val_any}, 32'd0);
    step(1'b0, 3'b000, 1'b0, 1'b1);
    chk("t6_no_route2", {31'd0, s_val_any}, 32'd0);

    // Random traffic: mostly-held requests, random acks, beats and rare resets.
    rq = '0;
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < N; i++) if ($urandom_range(0, 9) == 0) rq[i] = ~rq[i];
      ack = m_busy && !m_acked && ($urandom_range(0, 2) == 0);
      step(($urandom_range(0, 299) == 0), rq, ack, ($urandom_range(0, 2) == 0));
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
